// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcodes, functs,
// ALU operation codes, forward-select codes and the decoded control bundle.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUOUTM = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_dst;
    logic       alu_src_b;
    logic [2:0] alu_control;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(10'b0000000000);

endpackage

// File: rtl/pipe_ctrl_decoder.sv
// ctrl_decoder: combinational D-stage decode of Opcode/Funct into the control
// bundle; anything not recognised decodes to an all-zero bubble.
module ctrl_decoder
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  logic       rtype_ok_s;
  logic [2:0] rtype_alu_s;

  // R-type ALU operation from funct, with a flag for unsupported functs
  always_comb begin
    rtype_ok_s  = 1'b1;
    rtype_alu_s = ALU_ADD;
    case (funct)
      FN_ADD:  rtype_alu_s = ALU_ADD;
      FN_SUB:  rtype_alu_s = ALU_SUB;
      FN_AND:  rtype_alu_s = ALU_AND;
      FN_OR:   rtype_alu_s = ALU_OR;
      FN_SLT:  rtype_alu_s = ALU_SLT;
      default: rtype_ok_s  = 1'b0;
    endcase
  end

  // main opcode decode
  always_comb begin
    ctrl = CTRL_BUBBLE;
    case (opcode)
      OP_RTYPE: begin
        if (rtype_ok_s) begin
          ctrl.reg_write   = 1'b1;
          ctrl.reg_dst     = 1'b1;
          ctrl.alu_control = rtype_alu_s;
        end else begin
          ctrl = CTRL_BUBBLE;
        end
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_b   = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_b   = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_b   = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: ctrl = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: control pipeline plus hazard/forwarding unit for the 5-stage MIPS.
// Define PIPE_CTRL_FORWARD_EN for forwarding; otherwise dependents stall until the producer reaches W.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             branch_boolean,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  output logic             RegDstE,
  output logic             ALUSrcBE,
  output logic [2:0]       ALUControlE,
  output logic             MemWriteM,
  output logic             RegWriteW,
  output logic             MemToRegW,
  output logic             PCSrc,
  output logic             JumpD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE
);

  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

  ctrl_t      dec_s;
  logic       reg_write_e_r, mem_to_reg_e_r, mem_write_e_r, reg_dst_e_r, alu_src_b_e_r;
  logic [2:0] alu_control_e_r;
  logic       reg_write_m_r, mem_to_reg_m_r, mem_write_m_r;
  logic       reg_write_w_r, mem_to_reg_w_r;
  logic       stall_s;
  logic [1:0] fwd_ae_s, fwd_be_s;
  logic       fwd_ad_s, fwd_bd_s;

  ctrl_decoder u_decoder (
    .opcode (Opcode),
    .funct  (Funct),
    .ctrl   (dec_s)
  );

`ifdef PIPE_CTRL_FORWARD_EN
  logic lw_stall_s, branch_stall_s;

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] dst_m, input logic we_m,
                                         input logic [REG_W-1:0] dst_w, input logic we_w);
    logic [1:0] sel;
    if ((src != REG_ZERO) && (src == dst_m) && we_m) begin
      sel = FWD_ALUOUTM;
    end else if ((src != REG_ZERO) && (src == dst_w) && we_w) begin
      sel = FWD_RESULTW;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

  // only load-use and branch-compare dependencies stall; the rest forward
  always_comb begin
    lw_stall_s     = mem_to_reg_e_r & ((RsD == RtE) | (RtD == RtE));
    branch_stall_s = dec_s.branch &
                     ((reg_write_e_r  & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                      (mem_to_reg_m_r & ((WriteRegM == RsD) | (WriteRegM == RtD))));
    stall_s  = lw_stall_s | branch_stall_s;
    fwd_ae_s = fwd_sel(RsE, WriteRegM, reg_write_m_r, WriteRegW, reg_write_w_r);
    fwd_be_s = fwd_sel(RtE, WriteRegM, reg_write_m_r, WriteRegW, reg_write_w_r);
    fwd_ad_s = (RsD != REG_ZERO) & (RsD == WriteRegM) & reg_write_m_r;
    fwd_bd_s = (RtD != REG_ZERO) & (RtD == WriteRegM) & reg_write_m_r;
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{RsE, RtE, WriteRegW};

  // any nonzero source still being produced in E or M holds D; W is covered by write-before-read
  always_comb begin
    stall_s  = ((RsD != REG_ZERO) & (((RsD == WriteRegE) & reg_write_e_r) |
                                     ((RsD == WriteRegM) & reg_write_m_r))) |
               ((RtD != REG_ZERO) & (((RtD == WriteRegE) & reg_write_e_r) |
                                     ((RtD == WriteRegM) & reg_write_m_r)));
    fwd_ae_s = FWD_REG;
    fwd_be_s = FWD_REG;
    fwd_ad_s = 1'b0;
    fwd_bd_s = 1'b0;
  end
`endif

  // E-stage control register; a hazard cycle loads a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_e_r   <= 1'b0;
      mem_to_reg_e_r  <= 1'b0;
      mem_write_e_r   <= 1'b0;
      reg_dst_e_r     <= 1'b0;
      alu_src_b_e_r   <= 1'b0;
      alu_control_e_r <= 3'b000;
    end else if (stall_s) begin
      reg_write_e_r   <= 1'b0;
      mem_to_reg_e_r  <= 1'b0;
      mem_write_e_r   <= 1'b0;
      reg_dst_e_r     <= 1'b0;
      alu_src_b_e_r   <= 1'b0;
      alu_control_e_r <= 3'b000;
    end else begin
      reg_write_e_r   <= dec_s.reg_write;
      mem_to_reg_e_r  <= dec_s.mem_to_reg;
      mem_write_e_r   <= dec_s.mem_write;
      reg_dst_e_r     <= dec_s.reg_dst;
      alu_src_b_e_r   <= dec_s.alu_src_b;
      alu_control_e_r <= dec_s.alu_control;
    end
  end

  // M and W stages shift unconditionally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_m_r  <= 1'b0;
      mem_to_reg_m_r <= 1'b0;
      mem_write_m_r  <= 1'b0;
      reg_write_w_r  <= 1'b0;
      mem_to_reg_w_r <= 1'b0;
    end else begin
      reg_write_m_r  <= reg_write_e_r;
      mem_to_reg_m_r <= mem_to_reg_e_r;
      mem_write_m_r  <= mem_write_e_r;
      reg_write_w_r  <= reg_write_m_r;
      mem_to_reg_w_r <= mem_to_reg_m_r;
    end
  end

  assign RegDstE     = reg_dst_e_r;
  assign ALUSrcBE    = alu_src_b_e_r;
  assign ALUControlE = alu_control_e_r;
  assign MemWriteM   = mem_write_m_r;
  assign RegWriteW   = reg_write_w_r;
  assign MemToRegW   = mem_to_reg_w_r;
  assign StallF      = stall_s;
  assign StallD      = stall_s;
  assign FlushE      = stall_s;
  // redirects are suppressed while D is held so they fire once, on the resolved cycle
  assign PCSrc       = dec_s.branch & branch_boolean & ~stall_s;
  assign JumpD       = dec_s.jump & ~stall_s;
  assign ForwardAE   = fwd_ae_s;
  assign ForwardBE   = fwd_be_s;
  assign ForwardAD   = fwd_ad_s;
  assign ForwardBD   = fwd_bd_s;

endmodule
